dcache_controller: RTL

- Direct-mapped, write-back, write-allocate data cache between the CPU datapath and the 32-bit-block main data memory.
- Consumes the READ/WRITE strobes from the control unit and the ALU-computed byte address.
- Returns READDATA, and returns BUSYWAIT, which the control unit mirrors onto HOLD to stall the PC.
- Hits complete with no stall; misses stall the CPU until write-back and refill finish.

---
 rtl/dcache_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU
// and a 32-bit-block data memory; misses stall the CPU via BUSYWAIT.
module dcache_controller #(
   parameter int INDEX_BITS = 3,
   parameter int TAG_BITS   = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [7:0]  ADDRESS,
   input  logic [7:0]  WRITEDATA,
   output logic [7:0]  READDATA,
   output logic        BUSYWAIT,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic [5:0]  MEM_ADDRESS,
   output logic [31:0] MEM_WRITEDATA,
   input  logic [31:0] MEM_READDATA,
   input  logic        MEM_BUSYWAIT
);

   localparam int LINES = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      REFILL
   } state_e;

   state_e                state_q;
   logic [LINES-1:0]      valid_q;
   logic [LINES-1:0]      dirty_q;
   logic [TAG_BITS-1:0]   tag_q  [LINES];
   logic [31:0]           data_q [LINES];
   logic [7:0]            rdata_q;

   logic [TAG_BITS-1:0]   tag;
   logic [INDEX_BITS-1:0] idx;
   logic [1:0]            off;
   logic                  hit;
   logic                  access;
   logic                  load;
   logic [7:0]            sel_byte;

   assign tag      = ADDRESS[7:8-TAG_BITS];
   assign idx      = ADDRESS[2+:INDEX_BITS];
   assign off      = ADDRESS[1:0];
   assign hit      = valid_q[idx] && (tag_q[idx] == tag);
   assign access   = READ | WRITE;
   // simultaneous READ and WRITE is handled as a store
   assign load     = READ & ~WRITE;
   assign sel_byte = data_q[idx][{off, 3'b000} +: 8];

   always_comb begin
      BUSYWAIT      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = ADDRESS[7:2];
      MEM_WRITEDATA = data_q[idx];
      READDATA      = rdata_q;
      if (RESET) begin
         unique case (state_q)
            IDLE: begin
               BUSYWAIT = access & ~hit;
               if (load && hit) READDATA = sel_byte;
            end
            WRITEBACK: begin
               BUSYWAIT    = 1'b1;
               MEM_WRITE   = 1'b1;
               MEM_ADDRESS = {tag_q[idx], idx};
            end
            REFILL: begin
               BUSYWAIT = 1'b1;
               MEM_READ = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         rdata_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (access) begin
                  if (hit) begin
                     if (WRITE) begin
                        data_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
                        dirty_q[idx] <= 1'b1;
                     end else begin
                        rdata_q <= sel_byte;
                     end
                  end else if (valid_q[idx] && dirty_q[idx]) begin
                     state_q <= WRITEBACK;
                  end else begin
                     state_q <= REFILL;
                  end
               end
            end
            WRITEBACK: begin
               if (!MEM_BUSYWAIT) state_q <= REFILL;
            end
            REFILL: begin
               if (!MEM_BUSYWAIT) begin
                  data_q[idx]  <= MEM_READDATA;
                  tag_q[idx]   <= tag;
                  valid_q[idx] <= 1'b1;
                  dirty_q[idx] <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
